// File: rtl/onehot_sweep_decoder_if.sv
// onehot_sweep_decoder_if: request/response bundle; the abort port exists only with SWEEP_ABORT_EN
interface onehot_sweep_decoder_if #(parameter int IN_W = 6);
    localparam int OUT_W = 1 << IN_W;
    logic en;
    logic start;
    logic [IN_W-1:0] in;
    logic [OUT_W-1:0] out;
    logic [IN_W-1:0] idx;
    logic valid;
    logic busy;
    logic done;
`ifdef SWEEP_ABORT_EN
    logic abort;
`endif
    modport master (
`ifdef SWEEP_ABORT_EN
        output abort,
`endif
        output en, start, in,
        input out, idx, valid, busy, done
    );
    modport slave (
`ifdef SWEEP_ABORT_EN
        input abort,
`endif
        input en, start, in,
        output out, idx, valid, busy, done
    );
endinterface

// File: rtl/onehot_sweep_decoder.sv
// onehot_sweep_decoder: registered one-hot decoder with a self-timed sweep of every code.
// Define SWEEP_ABORT_EN to add the abort input that cancels a running sweep.
module onehot_sweep_decoder #(
    parameter int IN_W  = 6,
    parameter int DWELL = 1
) (
    input logic clk,
    input logic rst,
    onehot_sweep_decoder_if.slave bus
);
    localparam int OUT_W = 1 << IN_W;
    localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [IN_W-1:0] idx_n;
    logic valid_n, done_n;
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        idx_n   = '0;
        valid_n = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = SWEEP;
                    valid_n = 1'b1;
                end else if (bus.en) begin
                    idx_n   = bus.in;
                    valid_n = 1'b1;
                end
            end
            SWEEP: begin
`ifdef SWEEP_ABORT_EN
                if (bus.abort) state_n = IDLE;
                else
`endif
                if (cnt != 8'(DWELL - 1)) begin
                    idx_n   = bus.idx;
                    valid_n = 1'b1;
                    cnt_n   = cnt + 8'd1;
                end else if (&bus.idx) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    idx_n   = bus.idx + 1'b1;
                    valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.out   <= '0;
            bus.idx   <= '0;
            bus.valid <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bus.out   <= valid_n ? ONE << idx_n : '0;
            bus.idx   <= idx_n;
            bus.valid <= valid_n;
            bus.done  <= done_n;
        end
    end
    // busy depends only on the state register, so it stays free of input paths
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_onehot_sweep_decoder.sv
// tb_onehot_sweep_decoder: scoreboard bench driving a DWELL=1 and a DWELL=3 instance in lockstep.
module tb_onehot_sweep_decoder;
    typedef struct packed {
        logic [63:0] out;
        logic [5:0]  idx;
        logic        valid;
        logic        busy;
        logic        done;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q3[$];
    onehot_sweep_decoder_if #(.IN_W(6)) if1 ();
    onehot_sweep_decoder_if #(.IN_W(6)) if3 ();
    onehot_sweep_decoder #(.IN_W(6), .DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    onehot_sweep_decoder #(.IN_W(6), .DWELL(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    always #5 clk = ~clk;

    function automatic exp_t mk(bit v, int i, bit b, bit d);
        exp_t e;
        e.out   = v ? (64'd1 << i) : 64'd0;
        e.idx   = v ? 6'(i) : 6'd0;
        e.valid = v;
        e.busy  = b;
        e.done  = d;
        return e;
    endfunction

    // k-th output after the start edge of a sweep that dwells d cycles per code
    function automatic exp_t swp(int k, int d);
        if (k < 64 * d) return mk(1, k / d, 1, 0);
        if (k == 64 * d) return mk(0, 0, 1, 1);
        return mk(0, 0, 0, 0);
    endfunction

    function automatic exp_t got1();
        return {if1.out, if1.idx, if1.valid, if1.busy, if1.done};
    endfunction

    function automatic exp_t got3();
        return {if3.out, if3.idx, if3.valid, if3.busy, if3.done};
    endfunction

    task automatic cmp(string name, exp_t act, exp_t e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s got out=%h idx=%0d v=%b b=%b d=%b want out=%h idx=%0d v=%b b=%b d=%b",
                     name, act.out, act.idx, act.valid, act.busy, act.done,
                     e.out, e.idx, e.valid, e.busy, e.done);
        end
    endtask

    task automatic cyc(bit en, int in, bit start, bit abort, exp_t e1, exp_t e3);
        @(negedge clk);
        if1.en = en; if1.in = 6'(in); if1.start = start;
        if3.en = en; if3.in = 6'(in); if3.start = start;
`ifdef SWEEP_ABORT_EN
        if1.abort = abort; if3.abort = abort;
`else
        if (abort) $display("abort requested without SWEEP_ABORT_EN");
`endif
        q1.push_back(e1);
        q3.push_back(e3);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (q1.size() > 0) cmp("dwell1", got1(), q1.pop_front());
            else if (if1.valid || if1.done) cmp("dwell1_unexpected", got1(), mk(0, 0, 0, 0));
            if (q3.size() > 0) cmp("dwell3", got3(), q3.pop_front());
            else if (if3.valid || if3.done) cmp("dwell3_unexpected", got3(), mk(0, 0, 0, 0));
        end
    end

    initial begin
        exp_t z;
        z = mk(0, 0, 0, 0);
        if1.en = 0; if1.in = 0; if1.start = 0;
        if3.en = 0; if3.in = 0; if3.start = 0;
`ifdef SWEEP_ABORT_EN
        if1.abort = 0; if3.abort = 0;
`endif
        repeat (2) @(negedge clk);
        cmp("reset1", got1(), z);
        cmp("reset3", got3(), z);
        rst = 1'b0;
        // direct decode, including both ends of the index range
        cyc(1, 37, 0, 0, mk(1, 37, 0, 0), mk(1, 37, 0, 0));
        cyc(0, 37, 0, 0, z, z);
        cyc(1, 0, 0, 0, mk(1, 0, 0, 0), mk(1, 0, 0, 0));
        cyc(1, 63, 0, 0, mk(1, 63, 0, 0), mk(1, 63, 0, 0));
        cyc(0, 0, 0, 0, z, z);
        // start with en/in=10 in the same cycle: sweep wins; en/start while busy or in DONE ignored
        for (int k = 0; k < 196; k++) begin
            bit e, s;
            e = (k == 0) || (k >= 5 && k <= 10) || (k == 65);
            s = (k == 0) || (k == 8) || (k == 65);
            cyc(e, (k == 0) ? 10 : 9, s, 0, swp(k, 1), swp(k, 3));
        end
        cyc(0, 0, 0, 0, z, z);
        // asynchronous reset in the middle of a sweep
        for (int k = 0; k <= 20; k++) cyc(k == 0, 0, k == 0, 0, swp(k, 1), swp(k, 3));
        @(negedge clk);
        rst = 1'b1;
        #1;
        cmp("async_rst1", got1(), z);
        cmp("async_rst3", got3(), z);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 5, 0, 0, mk(1, 5, 0, 0), mk(1, 5, 0, 0));
        cyc(0, 0, 0, 0, z, z);
`ifdef SWEEP_ABORT_EN
        for (int k = 0; k <= 40; k++) cyc(k == 0, 0, k == 0, 0, swp(k, 1), swp(k, 3));
        cyc(0, 0, 0, 1, z, z);
        cyc(0, 0, 0, 0, z, z);
        cyc(0, 0, 0, 1, z, z);
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            errors++;
            $display("FAIL drain got q1=%0d q3=%0d want 0", q1.size(), q3.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
